// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the image-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 64;
  localparam int MEM_DEPTH = 49152;
  localparam int BURST_MAX = 8;
  localparam int IDX_W     = 3;  // enough for up to 8 requesters

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic             is_err;
    logic [IDX_W-1:0] idx;
  } resp_tag_t;

  function automatic logic addr_in_range(input logic [31:0] a, input int depth);
    return a < 32'(depth);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle: packed per-lane request fields plus grant/response strobes.
interface mem_port_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        lock;
  logic [NREQ-1:0]        we;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [NREQ-1:0]        err;
  logic [DATA_W-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, err, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_picker #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             any
);

  always_comb begin
    int j;
    logic found;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with short locked bursts sharing one image-memory port;
// read data returns one cycle after grant, out-of-range accesses raise err instead.
module mem_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W,
  parameter int MEM_DEPTH = mem_arb_pkg::MEM_DEPTH,
  parameter int BURST_MAX = mem_arb_pkg::BURST_MAX
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_inputData,
  output logic                mem_writeEnable,
  input  logic [DATA_W-1:0]   mem_out
);
  import mem_arb_pkg::*;

  localparam int PTR_W = $clog2(NREQ);
  localparam int BC_W  = $clog2(BURST_MAX + 1);

  arb_state_t        state_reg, state_next;
  logic [PTR_W-1:0]  owner_reg, owner_next;
  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [BC_W-1:0]   bc_reg, bc_next;
  resp_tag_t         tag_reg, tag_next;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];
  logic [NREQ-1:0]   pick_vec, gnt_vec, rvalid_vec, err_vec;
  logic              pick_any, owner_hold, grant_any, sel_in_range, burst_cont;
  logic [PTR_W-1:0]  pick_idx, gnt_idx;
  logic [BC_W-1:0]   cur_bc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign addr_arr[gi]   = bus.addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = bus.wdata[gi*DATA_W +: DATA_W];
      assign rvalid_vec[gi] = tag_reg.valid && !tag_reg.is_err && (tag_reg.idx == IDX_W'(gi));
      assign err_vec[gi]    = tag_reg.valid &&  tag_reg.is_err && (tag_reg.idx == IDX_W'(gi));
    end
  endgenerate

  rr_priority_picker #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req  (bus.req),
    .ptr  (rr_ptr_reg),
    .pick (pick_vec),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_vec[k]) pick_idx = PTR_W'(k);
    end
  end

  // A locked owner that still requests wins outright; otherwise fall back to the picker.
  assign owner_hold = (state_reg == LOCKED) && bus.req[owner_reg];

  always_comb begin
    gnt_vec = '0;
    gnt_idx = pick_idx;
    cur_bc  = '0;
    if (owner_hold) begin
      gnt_vec[owner_reg] = 1'b1;
      gnt_idx            = owner_reg;
      cur_bc             = bc_reg;
    end else if (pick_any) begin
      gnt_vec = pick_vec;
    end
    if (rst) gnt_vec = '0;
  end

  assign grant_any    = |gnt_vec;
  assign sel_addr     = addr_arr[gnt_idx];
  assign sel_wdata    = wdata_arr[gnt_idx];
  assign sel_in_range = addr_in_range(32'(sel_addr), MEM_DEPTH);
  assign burst_cont   = bus.lock[gnt_idx] && ((32'(cur_bc) + 1) < BURST_MAX);

  assign mem_address     = grant_any ? sel_addr : '0;
  assign mem_inputData   = grant_any ? sel_wdata : '0;
  assign mem_writeEnable = grant_any && bus.we[gnt_idx] && sel_in_range;

  always_comb begin
    state_next  = IDLE;
    owner_next  = owner_reg;
    bc_next     = '0;
    rr_ptr_next = rr_ptr_reg;
    tag_next    = '0;
    if (grant_any) begin
      if (burst_cont) begin
        state_next = LOCKED;
        owner_next = gnt_idx;
        bc_next    = cur_bc + BC_W'(1);
      end else if (gnt_idx == PTR_W'(NREQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = gnt_idx + PTR_W'(1);
      end
      // Writes that land in range need no response; everything else gets a tag.
      tag_next.valid  = !bus.we[gnt_idx] || !sel_in_range;
      tag_next.is_err = !sel_in_range;
      tag_next.idx    = IDX_W'(gnt_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      bc_reg     <= '0;
      tag_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      bc_reg     <= bc_next;
      tag_reg    <= tag_next;
    end
  end

  assign bus.gnt    = gnt_vec;
  assign bus.rvalid = rvalid_vec;
  assign bus.err    = err_vec;
  assign bus.rdata  = (tag_reg.valid && !tag_reg.is_err) ? mem_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for bursts, lock drop and reset.
module tb_mem_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_inputData;
  logic          mem_writeEnable;
  logic [DW-1:0] mem_out;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .NREQ      (NREQ),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_DEPTH (49152),
    .BURST_MAX (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .mem_address     (mem_address),
    .mem_inputData   (mem_inputData),
    .mem_writeEnable (mem_writeEnable),
    .mem_out         (mem_out)
  );

  // Small registered-output memory aliased on the low address byte.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_writeEnable) mem[mem_address[7:0]] <= mem_inputData;
    mem_out <= mem[mem_address[7:0]];
  end

  typedef struct {
    logic [3:0]  req, lock, we;
    logic [63:0] addr, wd;
    logic [3:0]  e_gnt;
    logic        e_mwe;
    logic [15:0] e_maddr;
    logic [63:0] e_mdata;
    logic [3:0]  e_rvalid, e_err;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [63:0] ADR  = 64'h0004_0003_0002_0001;
  localparam logic [63:0] DEAD = 64'hDEADBEEF_CAFEF00D;

  task automatic addv(input logic [3:0] rq, lk, w, input logic [63:0] a, d,
                      input logic [3:0] g, input logic mwe, input logic [15:0] ma,
                      input logic [63:0] md, input logic [3:0] rv, er, input logic [63:0] rd);
    vec_t v;
    v.req = rq; v.lock = lk; v.we = w; v.addr = a; v.wd = d;
    v.e_gnt = g; v.e_mwe = mwe; v.e_maddr = ma; v.e_mdata = md;
    v.e_rvalid = rv; v.e_err = er; v.e_rdata = rd;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [3:0] rq, lk, w, input logic [63:0] a, d);
    bus.req   = rq;
    bus.lock  = lk;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = {4{d}};
  endtask

  task automatic chk(input string nm, input logic [63:0] act, exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] rq, lk, input logic [63:0] a,
                      input logic [3:0] eg);
    drive(rq, lk, 4'b0000, a, 64'h0);
    #1;
    chk({nm, ".gnt"}, 64'(bus.gnt), 64'(eg));
    $display("[TB] %s req=%b lock=%b gnt=%b", nm, rq, lk, bus.gnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'h1111_0000_0000_0000 | 64'(i);

    //   req    lock   we     addr                   wd     gnt    mwe  maddr     mdata  rvalid err    rdata
    addv(4'hF, 4'h0, 4'h0, ADR,                   64'h0, 4'h1, 0, 16'h0001, 64'h0, 4'h0, 4'h0, 64'h0);
    addv(4'hF, 4'h0, 4'h0, ADR,                   64'h0, 4'h2, 0, 16'h0002, 64'h0, 4'h1, 4'h0, 64'h1111_0000_0000_0001);
    addv(4'hF, 4'h0, 4'h0, ADR,                   64'h0, 4'h4, 0, 16'h0003, 64'h0, 4'h2, 4'h0, 64'h1111_0000_0000_0002);
    addv(4'hF, 4'h0, 4'h0, ADR,                   64'h0, 4'h8, 0, 16'h0004, 64'h0, 4'h4, 4'h0, 64'h1111_0000_0000_0003);
    addv(4'hF, 4'h0, 4'h0, ADR,                   64'h0, 4'h1, 0, 16'h0001, 64'h0, 4'h8, 4'h0, 64'h1111_0000_0000_0004);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h1, 4'h0, 64'h1111_0000_0000_0001);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h0, 4'h0, 64'h0);
    addv(4'h4, 4'h0, 4'h4, 64'h0000_0010_0000_0000, DEAD, 4'h4, 1, 16'h0010, DEAD,  4'h0, 4'h0, 64'h0);
    addv(4'h4, 4'h0, 4'h0, 64'h0000_0010_0000_0000, 64'h0, 4'h4, 0, 16'h0010, 64'h0, 4'h0, 4'h0, 64'h0);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h4, 4'h0, DEAD);
    addv(4'h1, 4'h0, 4'h0, 64'h0000_0000_0000_C000, 64'h0, 4'h1, 0, 16'hC000, 64'h0, 4'h0, 4'h0, 64'h0);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h0, 4'h1, 64'h0);
    addv(4'h2, 4'h0, 4'h2, 64'h0000_0000_FFFF_0000, 64'h55, 4'h2, 0, 16'hFFFF, 64'h55, 4'h0, 4'h0, 64'h0);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h0, 4'h2, 64'h0);
    addv(4'h4, 4'h0, 4'h0, 64'h0000_BFFF_0000_0000, 64'h0, 4'h4, 0, 16'hBFFF, 64'h0, 4'h0, 4'h0, 64'h0);
    addv(4'h0, 4'h0, 4'h0, ADR,                   64'h0, 4'h0, 0, 16'h0000, 64'h0, 4'h4, 4'h0, 64'h1111_0000_0000_00FF);

    // Reset state, with every requester asserting to show grants are held off.
    rst = 1'b1;
    drive(4'hF, 4'h0, 4'h0, ADR, 64'h0);
    #2;
    chk("reset.gnt",    64'(bus.gnt), 64'h0);
    chk("reset.mwe",    64'(mem_writeEnable), 64'h0);
    chk("reset.rvalid", 64'(bus.rvalid), 64'h0);
    chk("reset.err",    64'(bus.err), 64'h0);
    chk("reset.rdata",  bus.rdata, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].req, vt[i].lock, vt[i].we, vt[i].addr, vt[i].wd);
      #1;
      chk($sformatf("vec%0d.gnt", i),    64'(bus.gnt),         64'(vt[i].e_gnt));
      chk($sformatf("vec%0d.mwe", i),    64'(mem_writeEnable), 64'(vt[i].e_mwe));
      chk($sformatf("vec%0d.maddr", i),  64'(mem_address),     64'(vt[i].e_maddr));
      chk($sformatf("vec%0d.mdata", i),  mem_inputData,        vt[i].e_mdata);
      chk($sformatf("vec%0d.rvalid", i), 64'(bus.rvalid),      64'(vt[i].e_rvalid));
      chk($sformatf("vec%0d.err", i),    64'(bus.err),         64'(vt[i].e_err));
      chk($sformatf("vec%0d.rdata", i),  bus.rdata,            vt[i].e_rdata);
      $display("[TB] vec %0d req=%b we=%b gnt=%b mwe=%b maddr=%h rvalid=%b err=%b rdata=%h",
               i, vt[i].req, vt[i].we, bus.gnt, mem_writeEnable, mem_address, bus.rvalid, bus.err, bus.rdata);
      @(posedge clk);
      #1;
    end

    // Locked burst by requester 1 capped at eight grants, then rotation resumes at 2.
    step("burst.pre", 4'b0001, 4'b0000, ADR, 4'b0001);
    for (int k = 0; k < 8; k++) step($sformatf("burst%0d", k), 4'b1111, 4'b0010, ADR, 4'b0010);
    step("burst.after", 4'b1111, 4'b0010, ADR, 4'b0100);

    // Locked owner drops its request mid-burst; requester 3 is served immediately.
    step("drop.pre",  4'b0011, 4'b0010, ADR, 4'b0001);
    step("drop.lk0",  4'b1010, 4'b0010, ADR, 4'b0010);
    step("drop.lk1",  4'b1010, 4'b0010, ADR, 4'b0010);
    step("drop.swap", 4'b1000, 4'b0000, ADR, 4'b1000);
    step("drop.idle", 4'b1111, 4'b0000, ADR, 4'b0001);

    // Reset right after a locked read grant: response dropped, lock released.
    step("rst.pre", 4'b0100, 4'b0100, 64'h0000_0005_0000_0000, 4'b0100);
    rst = 1'b1;
    drive(4'hF, 4'h0, 4'h0, ADR, 64'h0);
    #1;
    chk("rst.rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst.err",    64'(bus.err), 64'h0);
    chk("rst.rdata",  bus.rdata, 64'h0);
    chk("rst.gnt",    64'(bus.gnt), 64'h0);
    chk("rst.mwe",    64'(mem_writeEnable), 64'h0);
    $display("[TB] rst asserted gnt=%b rvalid=%b", bus.gnt, bus.rvalid);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst.post_rvalid", 64'(bus.rvalid), 64'h0);
    step("rst.post", 4'b1111, 4'b0100, ADR, 4'b0001);
    chk("rst.post_rv1", 64'(bus.rvalid), 64'h1);
    chk("rst.post_rd1", bus.rdata, 64'h1111_0000_0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares one port of the 64-bit dual-port image data memory between NREQ requesters (vector lanes, image loader, host writeback). Grants at most one access per cycle, drives the memory port address/data/write-enable, and routes the one-cycle-later read data back to the granted requester. Supports short locked bursts and rejects out-of-range addresses without touching memory.

## Interface
- NREQ, 4: number of requesters (2..8)
- ADDR_W, 16: word address width
- DATA_W, 64: word width
- MEM_DEPTH, 49152: valid words; addresses >= MEM_DEPTH are errors
- BURST_MAX, 8: max consecutive grants to a locked owner

- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester access request
- lock  in  NREQ  owner requests to keep the port next cycle
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*ADDR_W  packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  NREQ*DATA_W  packed write data
- gnt  out  NREQ  one-hot grant, same cycle as accepted req
- rvalid  out  NREQ  one-hot read-response strobe
- err  out  NREQ  one-hot out-of-range strobe
- rdata  out  DATA_W  read data, valid with rvalid
- mem_address  out  ADDR_W  to memory port address
- mem_inputData  out  DATA_W  to memory port write data
- mem_writeEnable  out  1  to memory port write enable
- mem_out  in  DATA_W  memory port registered output

## Operation
- States: IDLE (no owner) and LOCKED (owner o, burst count bc).
- IDLE: grant lowest index at or after rr_ptr (wrapping) with req=1. None: gnt=0, mem_writeEnable=0.
- LOCKED: if req[o]=1, o is granted regardless of others; if req[o]=0, go IDLE and arbitrate normally in the same cycle.
- After a grant to i: if lock[i]=1 and bc+1 < BURST_MAX, next state LOCKED(o=i, bc+1); else IDLE with rr_ptr = (i+1) mod NREQ, bc=0.
- On BURST_MAX reached, owner loses lock even if lock held; rr_ptr advances past it.
- Granted request drives mem_address=addr[i], mem_inputData=wdata[i], mem_writeEnable=we[i] & in-range.
- Out-of-range (addr >= MEM_DEPTH): grant still issued, mem_writeEnable forced 0, next cycle err[i]=1, rvalid[i]=0, rdata=0.
- In-range read: next cycle rvalid[i]=1, rdata=mem_out. In-range write: complete at grant; no rvalid.
- Non-granted requesters hold req/we/addr/wdata stable until gnt.
- Ungranted cycles: mem_address, mem_inputData driven 0.

## Timing
- gnt and mem_* combinational from req/lock/state; rvalid, err and response tag registered; rdata = mem_out muxed by registered tag (zero when no valid read).
- Read latency: exactly 1 cycle gnt -> rvalid. Throughput: one access per cycle.
- Reset values: rr_ptr=0, state IDLE, bc=0, rvalid=0, err=0, rdata=0, gnt=0 while rst high, mem_writeEnable=0.
- Reset mid-operation: in-flight response dropped (no rvalid after reset); lock released.
- Simultaneous req from all: strict rotation i, i+1, ... with no lock.
- rr_ptr wraps NREQ-1 -> 0.

## Structure
- Package mem_arb_pkg: ADDR_W, DATA_W, MEM_DEPTH constants; typedef enum {IDLE, LOCKED} arb_state_t; typedef struct for response tag (valid, is_err, idx).
- Sub-module rr_priority_picker: NREQ-wide one-hot pick from req vector and start pointer, purely combinational.
- Top holds state, rr_ptr, bc, response pipeline register and port muxes.

## Test plan
- Reset then req=4'b1111 all reads, no lock -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rvalid same sequence delayed 1 cycle.
- Requester 2 writes 0xDEADBEEF_CAFEF00D to addr 0x0010, then reads 0x0010 -> mem_writeEnable=1 at cycle 0, rvalid[2]=1 with rdata=0xDEADBEEF_CAFEF00D two cycles after write grant.
- Requester 1 holds req+lock, others requesting, BURST_MAX=8 -> 8 consecutive gnt[1], then gnt[2], rr_ptr=2.
- Requester 0 reads addr 49152 (0xC000) -> gnt[0], mem_writeEnable=0, next cycle err[0]=1, rvalid=0, rdata=0.
- Assert rst the cycle after a granted read -> no rvalid, all outputs 0, next grant starts from requester 0.
- Locked owner drops req mid-burst while requester 3 requests -> gnt[3] same cycle, state IDLE.
